// File: rtl/td4_fetch_decode.sv
// TD4 fetch/decode stage: 16x8 writable program ROM, IDLE/FETCH/EXEC sequencer and decoder.
// Optional macro ILLEGAL_TRAP_EN traps undefined opcodes into a sticky halt.
module td4_fetch_decode #(
  parameter int unsigned ROM_DEPTH = 16,
  parameter logic [7:0]  INIT_NOP  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] pc_in,
  input  logic       carry_in,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [3:0] imm,
  output logic [1:0] sel,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       pc_inc,
  output logic       pc_jump,
  output logic       c_flag,
  output logic       busy,
  output logic       illegal
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_t;

  state_t     r_state;
  state_t     w_state_d;
  logic [7:0] r_ir;
  logic       r_c_flag;
  // Power-up contents only; reset deliberately leaves the program intact.
  logic [7:0] r_rom [ROM_DEPTH] = '{default: INIT_NOP};

  logic       w_exec;
  logic       w_trap;
  logic       w_halted;
  logic [1:0] w_sel;
  logic       w_ld_a;
  logic       w_ld_b;
  logic       w_ld_out;
  logic       w_pc_inc;
  logic       w_pc_jump;
  logic       w_undef;

  assign w_exec = (r_state == StExec);

  always_comb begin
    w_sel     = 2'b00;
    w_ld_a    = 1'b0;
    w_ld_b    = 1'b0;
    w_ld_out  = 1'b0;
    w_pc_inc  = 1'b1;
    w_pc_jump = 1'b0;
    w_undef   = 1'b0;
    case (r_ir[7:4])
      4'h0: w_ld_a = 1'b1;
      4'h5: begin w_sel = 2'b01; w_ld_b   = 1'b1; end
      4'h3: begin w_sel = 2'b11; w_ld_a   = 1'b1; end
      4'h7: begin w_sel = 2'b11; w_ld_b   = 1'b1; end
      4'h1: begin w_sel = 2'b01; w_ld_a   = 1'b1; end
      4'h4: w_ld_b = 1'b1;
      4'h2: begin w_sel = 2'b10; w_ld_a   = 1'b1; end
      4'h6: begin w_sel = 2'b10; w_ld_b   = 1'b1; end
      4'h9: begin w_sel = 2'b01; w_ld_out = 1'b1; end
      4'hB: begin w_sel = 2'b11; w_ld_out = 1'b1; end
      4'hF: begin w_pc_inc = 1'b0; w_pc_jump = 1'b1; end
      4'hE: begin
        if (!r_c_flag) begin
          w_pc_inc  = 1'b0;
          w_pc_jump = 1'b1;
        end
      end
      default: w_undef = 1'b1;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  assign w_trap   = w_exec & w_undef;
  assign w_halted = r_illegal;
  assign illegal  = r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_trap) begin
      r_illegal <= 1'b1;
    end
  end
`else
  assign w_trap   = 1'b0;
  assign w_halted = 1'b0;
  assign illegal  = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (run && !w_halted) w_state_d = StFetch;
      StFetch: w_state_d = StExec;
      StExec:  w_state_d = (run && !w_trap) ? StFetch : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_ir     <= 8'h00;
      r_c_flag <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StFetch) begin
        r_ir <= r_rom[pc_in];
      end
      if (w_exec) begin
        r_c_flag <= carry_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && (r_state == StIdle)) begin
      r_rom[prog_addr] <= prog_data;
    end
  end

  // A trapped opcode issues no strobes at all.
  assign imm     = r_ir[3:0];
  assign sel     = w_exec ? w_sel : 2'b00;
  assign ld_a    = w_exec & w_ld_a;
  assign ld_b    = w_exec & w_ld_b;
  assign ld_out  = w_exec & w_ld_out;
  assign pc_inc  = w_exec & w_pc_inc & ~w_trap;
  assign pc_jump = w_exec & w_pc_jump;
  assign c_flag  = r_c_flag;
  assign busy    = (r_state != StIdle);

endmodule

// File: doc/td4_fetch_decode.md
Name: td4_fetch_decode

Overview:
- Fetch/decode stage directly downstream of the 4-bit program counter.
- Takes the PC value, reads a 16x8 program ROM, latches the instruction and decodes the TD4 instruction set.
- Produces the register-load, mux-select, immediate and PC-control strobes for the datapath. It also owns the carry flag.
- Two-cycle instruction cadence (FETCH, EXEC), gated by a run input; the ROM is writable while idle.

Parameters:
- ROM_DEPTH, 16, number of program words; fixed to 2^4 to match the 4-bit PC.
- INIT_NOP, 8'h00, reset contents of every ROM word.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- run  input  1  1 = execute program, 0 = go/stay IDLE at next instruction boundary
- pc_in  input  4  current program counter value
- carry_in  input  1  ALU carry-out of the current instruction
- prog_we  input  1  ROM write strobe; honoured only in IDLE
- prog_addr  input  4  ROM write address
- prog_data  input  8  ROM write data
- imm  output  4  immediate field, ir[3:0]
- sel  output  2  ALU source: 00 A, 01 B, 10 IN port, 11 zero
- ld_a  output  1  load register A (one EXEC cycle)
- ld_b  output  1  load register B
- ld_out  output  1  load output port register
- pc_inc  output  1  PC increment strobe (drives PC load)
- pc_jump  output  1  PC load-with-imm strobe
- c_flag  output  1  registered carry flag
- busy  output  1  state != IDLE
- illegal  output  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE, ir=8'h00, c_flag=0, illegal=0. All strobes are 0, imm=0, sel=00, busy=0. ROM contents are unaffected by reset except at power-up initialisation to INIT_NOP.
- State machine: IDLE, FETCH, EXEC.
  - IDLE: stays here while run=0. With run=1, goes to FETCH next cycle.
  - FETCH: ir <= rom[pc_in]; goes to EXEC.
  - EXEC: strobes are asserted for exactly this one cycle. On the clock edge ending EXEC, c_flag <= carry_in. Next state is FETCH if run=1, else IDLE.
- Strobes are decoded from ir, qualified by state==EXEC, and zero in every other state. There is no combinational path from any input to any output.
- Decode table (opcode = ir[7:4]; all defined non-jump ops also assert pc_inc):
  - 0000 ADD A,Im: sel=00, ld_a
  - 0101 ADD B,Im: sel=01, ld_b
  - 0011 MOV A,Im: sel=11, ld_a
  - 0111 MOV B,Im: sel=11, ld_b
  - 0001 MOV A,B: sel=01, ld_a
  - 0100 MOV B,A: sel=00, ld_b
  - 0010 IN A: sel=10, ld_a
  - 0110 IN B: sel=10, ld_b
  - 1001 OUT B: sel=01, ld_out
  - 1011 OUT Im: sel=11, ld_out
  - 1111 JMP Im: pc_jump, no pc_inc
  - 1110 JNC Im: pc_jump if c_flag==0, else pc_inc
  - any other opcode: NOP, pc_inc only
- Exclusivity: pc_inc and pc_jump are never both 1. At most one of ld_a/ld_b/ld_out is 1.
- Carry: c_flag is updated after every executed instruction, including jumps and NOPs. JNC tests the value latched by the previous instruction.
- PC wrap: 4'hF + inc wraps to 0; nothing special is required here.
- run deasserted mid-instruction: the current FETCH/EXEC pair completes, then the block goes to IDLE. No strobe is lost or duplicated.
- Programming: prog_we writes rom[prog_addr] <= prog_data only when state==IDLE. prog_we is ignored while busy. A write takes effect for a FETCH starting the following cycle.
- Reset mid-EXEC: strobes drop immediately (async) and no partial update is issued.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in EXEC sets illegal=1 (sticky until rst). No pc_inc or other strobes are issued, and the FSM goes to IDLE and stays there regardless of run until reset.
- Undefined: undefined opcodes execute as NOP (pc_inc only) and illegal is tied to 0.

Test Plan:
- Reset mid-EXEC of 8'h3A: assert rst -> ld_a, pc_inc, busy drop to 0 the same cycle; c_flag=0, illegal=0.
- Program rom[0]=8'h35 (MOV A,5), run=1, pc_in=0 -> one cycle after FETCH: ld_a=1, sel=11, imm=5, pc_inc=1 for exactly 1 cycle; no strobes in FETCH.
- rom[2]=8'hE9 (JNC 9): with c_flag=0 -> pc_jump=1, imm=9, pc_inc=0. Repeat after carry_in=1 in the prior EXEC -> pc_inc=1, pc_jump=0.
- prog_we=1, addr=3, data=8'hFF while busy -> rom[3] unchanged. The same write in IDLE -> later fetch at pc_in=3 gives pc_jump=1, imm=F.
- Drop run during FETCH -> EXEC completes with its strobes, then busy=0 next cycle, and the FSM stays IDLE.
- rom[4]=8'h80 with ILLEGAL_TRAP_EN -> illegal=1, no pc_inc, FSM IDLE even with run=1. Without the macro -> pc_inc=1 only, illegal=0.
